// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller.
// Holds the hazard FSM state encoding, default counter width and the
// default memory-wait watchdog limit, plus the load-use match helper.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_WAIT    = 2'd1,  // memory freeze in progress
    ST_RECOVER = 2'd2   // first cycle after a freeze ends
  } hz_state_e;

  localparam int CNT_W_DEF   = 16;
  localparam int TIMEOUT_DEF = 255;
  localparam int WD_W        = 8;

  // ID source matches the EX load destination; x0 never creates a hazard.
  function automatic logic load_use_match(
    input logic [4:0] rs1, input logic use1,
    input logic [4:0] rs2, input logic use2,
    input logic [4:0] rd
  );
    return (rd != 5'd0) && ((use1 && rs1 == rd) || (use2 && rs2 == rd));
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the hazard event statistics.
// Ports:
//   i_clk   - clock
//   i_clr_n - asynchronous active-low clear
//   i_inc   - increment enable (ignored once the counter is all ones)
//   o_cnt   - current count
module sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_clr_n,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n)                  r_cnt <= '0;
    else if (i_inc && r_cnt != '1) r_cnt <= r_cnt + W'(1);
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch/jump redirect flush
// and data-memory wait freeze, with event counters and a sticky watchdog.
// Priority: memory wait > redirect > load-use. Control outputs are
// combinational (zero latency) and forced low while reset is asserted.
// Ports:
//   i_clk, i_rst_n            - clock, asynchronous active-low reset
//   i_id_rs1/2, i_id_use_rs1/2 - ID source registers and their use flags
//   i_ex_rd, i_ex_load, i_ex_nop, i_ex_redirect - EX stage status
//   i_mem_req, i_mem_ready    - MEM stage access and memory completion
//   o_pc_hold, o_ifid_hold    - hold PC and IF/ID
//   o_ifid_flush              - squash IF/ID
//   o_idex_bubble             - insert nop into ID/EX
//   o_freeze                  - hold ID/EX, EX/MEM, MEM/WB
//   o_stall_cnt/o_flush_cnt/o_freeze_cnt - saturating event counters
//   o_mem_timeout             - sticky memory-wait watchdog flag
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_use_rs1,
  input  logic             i_id_use_rs2,
  input  logic [4:0]       i_ex_rd,
  input  logic             i_ex_load,
  input  logic             i_ex_nop,
  input  logic             i_ex_redirect,
  input  logic             i_mem_req,
  input  logic             i_mem_ready,
  output logic             o_pc_hold,
  output logic             o_ifid_hold,
  output logic             o_ifid_flush,
  output logic             o_idex_bubble,
  output logic             o_freeze,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt,
  output logic [CNT_W-1:0] o_freeze_cnt,
  output logic             o_mem_timeout
);

  hz_state_e       r_state, w_nstate;
  logic [WD_W-1:0] r_wd;
  logic            r_timeout;
  logic [WD_W:0]   w_wd_inc;

  logic w_wait, w_redir, w_lu;
  logic w_do_freeze, w_do_flush, w_do_stall;

  assign w_wait  = i_mem_req & ~i_mem_ready;
  assign w_redir = ~i_ex_nop & i_ex_redirect;
  assign w_lu    = ~i_ex_nop & i_ex_load &
                   load_use_match(i_id_rs1, i_id_use_rs1, i_id_rs2, i_id_use_rs2, i_ex_rd);

  // Reset gating makes every control output 0 while reset is low.
  assign w_do_freeze = i_rst_n & w_wait;
  assign w_do_flush  = i_rst_n & ~w_wait & w_redir;
  assign w_do_stall  = i_rst_n & ~w_wait & ~w_redir & w_lu;

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_RUN;
    else          r_state <= w_nstate;
  end

  // FSM next state and control outputs
  always_comb begin
    w_nstate      = r_state;
    o_freeze      = 1'b0;
    o_pc_hold     = 1'b0;
    o_ifid_hold   = 1'b0;
    o_ifid_flush  = 1'b0;
    o_idex_bubble = 1'b0;

    case (r_state)
      ST_RUN:     if (w_wait)      w_nstate = ST_WAIT;
      ST_WAIT:    if (i_mem_ready) w_nstate = ST_RECOVER;
      ST_RECOVER: w_nstate = w_wait ? ST_WAIT : ST_RUN;
      default:    w_nstate = ST_RUN;
    endcase

    // A wait freezes regardless of state; EX is held so a pending
    // redirect re-presents itself in the first unfrozen cycle.
    if (w_do_freeze) begin
      o_freeze    = 1'b1;
      o_pc_hold   = 1'b1;
      o_ifid_hold = 1'b1;
    end else if (w_do_flush) begin
      o_ifid_flush  = 1'b1;
      o_idex_bubble = 1'b1;
    end else if (w_do_stall) begin
      o_pc_hold     = 1'b1;
      o_ifid_hold   = 1'b1;
      o_idex_bubble = 1'b1;
    end
  end

  // Watchdog on consecutive wait cycles; the flag sets on the edge where
  // the count reaches TIMEOUT and stays set until reset.
  assign w_wd_inc = {1'b0, r_wd} + (WD_W+1)'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wd      <= '0;
      r_timeout <= 1'b0;
    end else if (w_wait) begin
      if (r_wd != '1) r_wd <= w_wd_inc[WD_W-1:0];
      if (w_wd_inc >= (WD_W+1)'(TIMEOUT)) r_timeout <= 1'b1;
    end else begin
      r_wd <= '0;
    end
  end

  assign o_mem_timeout = r_timeout;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .i_clk(i_clk), .i_clr_n(i_rst_n), .i_inc(w_do_stall),  .o_cnt(o_stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .i_clk(i_clk), .i_clr_n(i_rst_n), .i_inc(w_do_flush),  .o_cnt(o_flush_cnt)
  );

  sat_counter #(.W(CNT_W)) u_freeze_cnt (
    .i_clk(i_clk), .i_clr_n(i_rst_n), .i_inc(w_do_freeze), .o_cnt(o_freeze_cnt)
  );

endmodule
